// File: rtl/seq_divider_if.sv
// Start/done bundle between the arithmetic-unit sequencer and the restoring divider.
// dbg_state mirrors the divider FSM so checkers can bind to it without reaching inside.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, dbg_state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, dbg_state
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake,
// registered quotient/remainder/div_by_zero that hold until the next completion.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is sampled only on edges where busy=0; the accepting edge captures
    // dividend/divisor, busy stays high until the edge that raises the one-cycle done pulse,
    // and the result outputs change only on that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shq_q, shq_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial;
    logic             fits;

    assign trial = {rem_q, shq_q[WIDTH-1]};
    assign fits  = (trial >= {1'b0, dvsr_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shq_d   = shq_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvsr_d  = bus.divisor;
                    shq_d   = bus.dividend;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = (bus.divisor != '0) ? RUN : DZ;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    // Subtracted value is below the divisor, so WIDTH bits hold it exactly.
                    rem_d = fits ? (trial[WIDTH-1:0] - dvsr_q) : trial[WIDTH-1:0];
                    shq_d = {shq_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DZ: begin
                state_d = DONE;
            end
            DONE: begin
                // A zero divisor never shifted, so shq_q still holds the captured dividend.
                done_d  = 1'b1;
                dbz_d   = (dvsr_q == '0);
                quot_d  = (dvsr_q == '0) ? '1 : shq_q;
                remo_d  = (dvsr_q == '0) ? shq_q : rem_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shq_q   <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shq_q   <= shq_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider: a driver pushes expected results computed with
// plain / and %, and a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic prev_done;
    exp_t exp_q[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver tasks
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 64'(bus.busy), 64'd0);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.a   = a;
        e.b   = b;
        e.dz  = (b == '0);
        e.q   = e.dz ? {W{1'b1}} : a / b;
        e.r   = e.dz ? a : a % b;
        e.due = cyc + 1 + (e.dz ? 2 : W + 2);
        exp_q.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.done) begin
                chk("done_width", 64'(prev_done), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", 64'(bus.quotient), 64'(e.q));
                    chk("remainder", 64'(bus.remainder), 64'(e.r));
                    chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
                    chk("latency", 64'(cyc), 64'(e.due));
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
                    if (!e.dz) begin
                        chk("invariant", 64'(bus.quotient) * 64'(e.b) + 64'(bus.remainder), 64'(e.a));
                        chk("rem_lt_div", 64'(bus.remainder < e.b), 64'd1);
                    end
                end
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        prev_done    = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_quotient", 64'(bus.quotient), 64'd0);
        chk("rst_remainder", 64'(bus.remainder), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);

        // Directed cases including boundaries and divide-by-zero recovery
        do_div(32'd100, 32'd7);
        do_div(32'd5, 32'd0);
        do_div(32'd9, 32'd3);
        do_div(32'hFFFF_FFFF, 32'd1);
        do_div(32'd3, 32'd10);
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_div(32'd0, 32'd5);
        drain();

        // Start while busy must be ignored
        do_div(32'd1000, 32'd10);
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd7;
        bus.divisor  = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        chk("hold_quotient", 64'(bus.quotient), 64'd100);
        chk("hold_remainder", 64'(bus.remainder), 64'd0);
        chk("hold_dbz", 64'(bus.div_by_zero), 64'd0);

        // Asynchronous abort mid-divide
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_quotient", 64'(bus.quotient), 64'd0);
        chk("abort_remainder", 64'(bus.remainder), 64'd0);
        chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_div(32'd50, 32'd4);
        drain();

        // Random regression, back-to-back issue as soon as busy drops
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = '1;
                3:       b = a;
                4:       a = W'($urandom_range(0, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 4) b = W'($urandom_range(0, 3));
            do_div(a, b);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
